// File: rtl/formant_pkg.sv
// Shared types and constants for the formant tracker: FSM states and mode encodings.
package formant_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      EMIT = 2'd2
   } state_t;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_IIR    = 2'd1;
   localparam logic [1:0] MODE_REJECT = 2'd2;

endpackage

// File: rtl/formant_iir_step.sv
// One channel update: seed, bypass, first-order IIR or IIR with jump rejection.
// Purely combinational; the top time-shares a single instance across all channels.
module formant_iir_step
   import formant_pkg::*;
#(
   parameter int BIT_WIDTH   = 32,
   parameter int ALPHA_SHIFT = 2,
   parameter int MAX_JUMP    = 400,
   parameter int HOLD_FRAMES = 3,
   parameter int MISS_WIDTH  = 2
) (
   input  logic [BIT_WIDTH-1:0]  x_i,
   input  logic [BIT_WIDTH-1:0]  y_i,
   input  logic                  locked_i,
   input  logic [MISS_WIDTH-1:0] miss_i,
   input  logic [1:0]            mode_i,
   output logic [BIT_WIDTH-1:0]  y_o,
   output logic [MISS_WIDTH-1:0] miss_o
);

   localparam logic [BIT_WIDTH:0]    JUMP_LIM = (BIT_WIDTH+1)'(MAX_JUMP);
   localparam logic [MISS_WIDTH-1:0] HOLD_W   = MISS_WIDTH'(HOLD_FRAMES);

   logic signed [BIT_WIDTH:0] diff;
   logic signed [BIT_WIDTH:0] step;
   logic        [BIT_WIDTH:0] mag;
   logic        [BIT_WIDTH-1:0] iir_y;
   logic        [MISS_WIDTH-1:0] miss_inc;

   always_comb begin
      diff     = $signed({1'b0, x_i}) - $signed({1'b0, y_i});
      step     = diff >>> ALPHA_SHIFT;
      mag      = diff[BIT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      iir_y    = BIT_WIDTH'($signed({1'b0, y_i}) + step);
      miss_inc = miss_i + 1'b1;

      y_o    = x_i;
      miss_o = miss_i;
      if (!locked_i) begin
         miss_o = '0;
      end else if (mode_i == MODE_BYPASS) begin
         y_o = x_i;
      end else if (mode_i == MODE_REJECT) begin
         if (mag <= JUMP_LIM) begin
            y_o    = iir_y;
            miss_o = '0;
         end else if (miss_inc >= HOLD_W) begin
            // Persistent jump: accept it as the new track rather than fight it forever
            y_o    = x_i;
            miss_o = '0;
         end else begin
            y_o    = y_i;
            miss_o = miss_inc;
         end
      end else begin
         y_o = iir_y;
      end
   end

endmodule

// File: rtl/formant_tracker.sv
// Frame-to-frame formant smoother: one channel per cycle, then an ordered vector is emitted.
// Frames arriving while busy are dropped and counted rather than queued.
module formant_tracker
   import formant_pkg::*;
#(
   parameter int BIT_WIDTH   = 32,
   parameter int FORMANTS    = 5,
   parameter int ALPHA_SHIFT = 2,
   parameter int MAX_JUMP    = 400,
   parameter int HOLD_FRAMES = 3,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 formant_valid,
   input  logic [BIT_WIDTH-1:0] formant_freq [FORMANTS],
   input  logic                 frame_voiced,
   input  logic [1:0]           mode,
   output logic                 track_valid,
   output logic [BIT_WIDTH-1:0] track_freq [FORMANTS],
   output logic                 track_locked,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] dropped_frames
);

   localparam int KW = $clog2(FORMANTS + 1);
   localparam int IW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
   localparam int MW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [MW-1:0] HOLD_W = MW'(HOLD_FRAMES);

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic [BIT_WIDTH-1:0] x_q   [FORMANTS];
   logic [BIT_WIDTH-1:0] y_q   [FORMANTS];
   logic [MW-1:0]        miss_q [FORMANTS];
   logic [BIT_WIDTH-1:0] out_freq_q [FORMANTS];
   logic                 voiced_q;
   logic [1:0]           mode_q;
   logic                 locked_q, locked_d;
   logic [MW-1:0]        unv_q, unv_d;
   logic                 out_locked_q;
   logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

   logic                 latch_en, ch_we, commit;
   logic [IW-1:0]        idx;
   logic [BIT_WIDTH-1:0] y_step, y_prev, y_ord;
   logic [MW-1:0]        miss_step;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      latch_en = 1'b0;
      ch_we    = 1'b0;
      commit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (formant_valid) begin
               latch_en = 1'b1;
               k_d      = '0;
               state_d  = PROC;
            end
         end
         PROC: begin
            // The extra cycle at k == FORMANTS publishes the finished vector
            if (k_q == KW'(FORMANTS)) begin
               commit  = 1'b1;
               state_d = EMIT;
            end else begin
               ch_we = voiced_q;
               k_d   = k_q + 1'b1;
            end
         end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx    = (k_q >= KW'(FORMANTS)) ? IW'(FORMANTS - 1) : k_q[IW-1:0];
      y_prev = (idx == '0) ? '0 : y_q[idx - 1'b1];
      y_ord  = y_step;
      if (idx != '0 && y_step <= y_prev) begin
         y_ord = (y_prev == '1) ? y_prev : y_prev + 1'b1;
      end
   end

   formant_iir_step #(
      .BIT_WIDTH  (BIT_WIDTH),
      .ALPHA_SHIFT(ALPHA_SHIFT),
      .MAX_JUMP   (MAX_JUMP),
      .HOLD_FRAMES(HOLD_FRAMES),
      .MISS_WIDTH (MW)
   ) u_step (
      .x_i     (x_q[idx]),
      .y_i     (y_q[idx]),
      .locked_i(locked_q),
      .miss_i  (miss_q[idx]),
      .mode_i  (mode_q),
      .y_o     (y_step),
      .miss_o  (miss_step)
   );

   always_comb begin
      locked_d = 1'b1;
      unv_d    = '0;
      if (!voiced_q) begin
         unv_d    = (unv_q >= HOLD_W) ? unv_q : unv_q + 1'b1;
         locked_d = locked_q && (unv_d < HOLD_W);
      end
      dropped_d = dropped_q;
      if (formant_valid && state_q != IDLE && dropped_q != '1) begin
         dropped_d = dropped_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         k_q          <= '0;
         voiced_q     <= 1'b0;
         mode_q       <= MODE_BYPASS;
         locked_q     <= 1'b0;
         unv_q        <= '0;
         out_locked_q <= 1'b0;
         dropped_q    <= '0;
         for (int i = 0; i < FORMANTS; i++) begin
            x_q[i]        <= '0;
            y_q[i]        <= '0;
            miss_q[i]     <= '0;
            out_freq_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         dropped_q <= dropped_d;
         if (latch_en) begin
            x_q      <= formant_freq;
            voiced_q <= frame_voiced;
            mode_q   <= mode;
         end
         if (ch_we) begin
            y_q[idx]    <= y_ord;
            miss_q[idx] <= miss_step;
         end
         if (commit) begin
            locked_q     <= locked_d;
            unv_q        <= unv_d;
            out_locked_q <= locked_d;
            out_freq_q   <= y_q;
         end
      end
   end

   assign track_valid    = (state_q == EMIT);
   assign busy           = (state_q != IDLE);
   assign track_freq     = out_freq_q;
   assign track_locked   = out_locked_q;
   assign dropped_frames = dropped_q;

endmodule
